// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings (also used by the ALU control decoder), FSM states, widths.
package alu_pkg;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_SHAMT_W = 5;
  localparam int unsigned OP_W        = 4;

  // Op code is {funct7[5], funct3}
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for ops that go through the serial shifter; X or unknown codes fall to default
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops; anything that is not one of them (shifts, unknown, X) yields 0.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  // Op decode and compute
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle ops plus a 1-bit-per-cycle serial shifter behind valid/ready.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   aluctrl_ctrl_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic              zero_o
);

  state_t               state;
  logic [OP_W-1:0]      op_q;
  logic [XLEN-1:0]      work;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      comb_res;
  logic [XLEN-1:0]      first_shift;
  logic [XLEN-1:0]      next_work;
  logic                 accept;

  // One-bit shift step for the serial shifter
  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] x, input logic [OP_W-1:0] op);
    logic [XLEN-1:0] r;
    r = x;
    case (op)
      ALU_SLL: r = {x[XLEN-2:0], 1'b0};
      ALU_SRL: r = {1'b0, x[XLEN-1:1]};
      ALU_SRA: r = {x[XLEN-1], x[XLEN-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  alu_comb #(.XLEN(XLEN)) u_comb (
    .op     (aluctrl_ctrl_i),
    .a      (a_i),
    .b      (b_i),
    .result (comb_res)
  );

  assign shamt       = b_i[SHAMT_W-1:0];
  assign first_shift = shift1(a_i, aluctrl_ctrl_i);
  assign next_work   = shift1(work, op_q);
  assign accept      = valid_i && ready_o;
  assign valid_o     = (state == ST_DONE);

  // Ready: free in IDLE, busy while shifting, pass-through of downstream ready in DONE
  always_comb begin
    ready_o = 1'b0;
    case (state)
      ST_IDLE:  ready_o = 1'b1;
      ST_DONE:  ready_o = ready_i;
      default:  ready_o = 1'b0;
    endcase
  end

  // FSM, serial shifter and output registers; accept in DONE reloads exactly as from IDLE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      work     <= '0;
      cnt      <= '0;
      result_o <= '0;
      zero_o   <= 1'b0;
    end else if (accept) begin
      if (is_shift(aluctrl_ctrl_i)) begin
        op_q <= aluctrl_ctrl_i;
        if (shamt == '0) begin
          result_o <= a_i;
          zero_o   <= (a_i == '0);
          state    <= ST_DONE;
        end else begin
          work <= first_shift;
          cnt  <= shamt - SHAMT_W'(1);
          if (shamt == SHAMT_W'(1)) begin
            result_o <= first_shift;
            zero_o   <= (first_shift == '0);
            state    <= ST_DONE;
          end else begin
            state <= ST_SHIFT;
          end
        end
      end else begin
        result_o <= comb_res;
        zero_o   <= (comb_res == '0);
        state    <= ST_DONE;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          work <= next_work;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result_o <= next_work;
            zero_o   <= (next_work == '0);
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) state <= ST_IDLE;
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: expected results queued at accept, checked at result handshake.
module tb_alu_iter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result;
  logic        zero;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        prev_v  = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_res = '0;
  logic [3:0]  bb_ops[7];

  alu_iter dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .aluctrl_ctrl_i (op_s),
    .a_i            (a_s),
    .b_i            (b_s),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .result_o       (result),
    .zero_o         (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return 32'($signed(a) >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0001 || op == 4'b0101 || op == 4'b1101)
      return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
    return 1;
  endfunction

  // Monitor: inputs are stable from posedge+1 until the next posedge, so the negedge sees what the next edge will act on
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (valid_o && (!prev_v || prev_hs)) begin
        if (sb.size() == 0) check("spurious_valid", 32'd1, 32'd0);
        else                check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
      end
      if (valid_o && prev_v && !prev_hs) check("hold_result", result, prev_res);
      if (valid_o && !ready_i)           check("ready_o_stall", 32'(ready_o), 32'd0);
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("zero", 32'(zero), 32'(e.res == 32'd0));
        end
      end
      if (valid_i && ready_o)
        sb.push_back('{model(op_s, a_s, b_s), exp_lat(op_s, b_s), cyc + 1});
      prev_v   = valid_o;
      prev_hs  = valid_o && ready_i;
      prev_res = result;
    end
  end

  // Drive one request from posedge+1 and hold it until accepted
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    op_s    = op;
    a_s     = a;
    b_s     = b;
    valid_i = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      k++;
      if (k > 100) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || valid_o) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    check("watchdog", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bb_ops = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND};
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_s    = '0;
    a_s     = '0;
    b_s     = '0;
    #12;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-cycle and shift cases
    send(ALU_ADD,  32'hFFFF_FFFF, 32'd1);
    send(ALU_SUB,  32'd5,         32'd7);
    send(ALU_SLT,  32'hFFFF_FFFF, 32'd1);
    send(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    send(4'b1010,  32'h1234_5678, 32'h9ABC_DEF0);
    drain();
    send(ALU_SRA,  32'h8000_0000, 32'd4);
    drain();
    send(ALU_SRL,  32'h8000_0000, 32'd4);
    drain();
    send(ALU_SLL,  32'd1,         32'd31);
    drain();
    send(ALU_SRL,  32'h1234_5678, 32'h20);
    send(ALU_SRA,  32'h8000_0001, 32'h0000_0101);
    drain();
    for (int i = 0; i < 3; i++) begin
      send(ALU_SRA, $urandom, $urandom);
      drain();
    end

    // Backpressure, then a request accepted on the same edge the stalled result leaves
    ready_i = 1'b0;
    send(ALU_ADD, 32'd10, 32'd20);
    repeat (6) @(posedge clk);
    #1;
    ready_i = 1'b1;
    send(ALU_ADD, 32'd2, 32'd3);
    drain();

    // Back-to-back single-cycle ops
    for (int i = 0; i < 8; i++)
      send(bb_ops[$urandom_range(0, 6)], $urandom, $urandom);
    drain();

    // Asynchronous reset mid-shift
    send(ALU_OR, 32'h00F0_0000, 32'h0000_000F);
    send(ALU_SLL, 32'd1, 32'd20);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", 32'(zero), 32'd0);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    send(ALU_ADD, 32'd7, 32'd8);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
